// File: rtl/sfx_pkg.sv
// Shared types and default sizing for the sound-effect playback scheduler.
package sfx_pkg;

    localparam int SFX_N_SRC  = 4;
    localparam int SFX_ADDR_W = 17;
    localparam int SFX_DIV_W  = 16;
    localparam int SFX_ID_W   = $clog2(SFX_N_SRC);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        DONE
    } sfx_state_t;

endpackage

// File: rtl/sfx_pace_counter.sv
// Sample pacing counter: counts up to div and holds there; tick marks "divider elapsed".
module sfx_pace_counter
    import sfx_pkg::*;
#(
    parameter int DIV_W = SFX_DIV_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count_reg;

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != div)) begin
            count_reg <= count_reg + DIV_W'(1);
        end
    end

    assign tick = (count_reg == div);

endmodule

// File: rtl/sfx_playback_scheduler.sv
// Fixed-priority arbiter/stepper sharing one sample-address stream among N_SRC sound sources.
// Build option: define SFX_PREEMPT_EN to let a higher-priority request abort the clip in progress.
module sfx_playback_scheduler
    import sfx_pkg::*;
#(
    parameter int N_SRC  = SFX_N_SRC,
    parameter int ADDR_W = SFX_ADDR_W,
    parameter int DIV_W  = SFX_DIV_W,
    parameter int ID_W   = $clog2(N_SRC)
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         INIT_FINISH,
    input  logic                         data_over,
    input  logic [N_SRC-1:0]             req,
    input  logic [N_SRC-1:0][ADDR_W-1:0] req_base,
    input  logic [N_SRC-1:0][ADDR_W-1:0] req_len,
    input  logic [N_SRC-1:0][DIV_W-1:0]  req_div,
    output logic                         INIT_audio,
    output logic [ADDR_W-1:0]            sample_addr,
    output logic                         busy,
    output logic [ID_W-1:0]              active_id,
    output logic                         done,
    output logic [ID_W-1:0]              done_id
);

    sfx_state_t        state_reg;
    logic [N_SRC-1:0]  pending_reg, pending_next, clr_mask;
    logic [ID_W-1:0]   grant, active_id_reg, done_id_reg;
    logic [ADDR_W-1:0] base_reg, len_reg, offset_reg, sample_addr_reg;
    logic [DIV_W-1:0]  div_reg;
    logic              done_reg, init_audio_reg;
    logic              tick, preempt, advance, last;

    // Lowest set index wins.
    always_comb begin
        grant = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pending_reg[i]) grant = ID_W'(i);
        end
    end

    // A new request in the same cycle as the load-clear keeps the bit set.
    always_comb begin
        clr_mask = '0;
        if (state_reg == LOAD) clr_mask[grant] = 1'b1;
        pending_next = (pending_reg & ~clr_mask) | req;
    end

`ifdef SFX_PREEMPT_EN
    logic [N_SRC-1:0] higher;
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_higher
        assign higher[gi] = pending_reg[gi] && (gi < int'(active_id_reg));
    end
    assign preempt = (state_reg == PLAY) && (|higher);
`else
    assign preempt = 1'b0;
`endif

    assign advance = (state_reg == PLAY) && !preempt && tick && data_over;
    assign last    = (offset_reg == len_reg - ADDR_W'(1));

    sfx_pace_counter #(
        .DIV_W (DIV_W)
    ) u_pace (
        .Clk    (Clk),
        .Reset  (Reset),
        .clear  ((state_reg == LOAD) || advance),
        .enable (state_reg == PLAY),
        .div    (div_reg),
        .tick   (tick)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg       <= IDLE;
            pending_reg     <= '0;
            sample_addr_reg <= '0;
            offset_reg      <= '0;
            base_reg        <= '0;
            len_reg         <= '0;
            div_reg         <= '0;
            active_id_reg   <= '0;
            done_reg        <= 1'b0;
            done_id_reg     <= '0;
            init_audio_reg  <= 1'b0;
        end else begin
            init_audio_reg <= 1'b1;
            pending_reg    <= pending_next;
            done_reg       <= 1'b0;
            case (state_reg)
                IDLE: begin
                    sample_addr_reg <= '0;
                    if (INIT_FINISH && (|pending_reg)) state_reg <= LOAD;
                end
                LOAD: begin
                    base_reg        <= req_base[grant];
                    len_reg         <= req_len[grant];
                    div_reg         <= req_div[grant];
                    active_id_reg   <= grant;
                    offset_reg      <= '0;
                    sample_addr_reg <= req_base[grant];
                    if (req_len[grant] == '0) begin
                        state_reg   <= DONE;
                        done_reg    <= 1'b1;
                        done_id_reg <= grant;
                    end else begin
                        state_reg <= PLAY;
                    end
                end
                PLAY: begin
                    if (preempt) begin
                        state_reg <= LOAD;
                    end else if (advance) begin
                        // Final sample: leave the address on the last sample of the clip.
                        if (last) begin
                            state_reg   <= DONE;
                            done_reg    <= 1'b1;
                            done_id_reg <= active_id_reg;
                        end else begin
                            offset_reg      <= offset_reg + ADDR_W'(1);
                            sample_addr_reg <= base_reg + offset_reg + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    sample_addr_reg <= '0;
                    state_reg       <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign INIT_audio  = init_audio_reg;
    assign sample_addr = sample_addr_reg;
    assign busy        = (state_reg == LOAD) || (state_reg == PLAY);
    assign active_id   = active_id_reg;
    assign done        = done_reg;
    assign done_id     = done_id_reg;

endmodule

// File: tb/tb_sfx_playback_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a clip-level reference model.
module tb_sfx_playback_scheduler;

    localparam int N  = 4;
    localparam int AW = 17;
    localparam int DW = 16;

    logic                 Clk = 1'b0;
    logic                 Reset = 1'b1;
    logic                 INIT_FINISH = 1'b0;
    logic                 data_over = 1'b0;
    logic [N-1:0]         req = '0;
    logic [N-1:0][AW-1:0] req_base = '0;
    logic [N-1:0][AW-1:0] req_len = '0;
    logic [N-1:0][DW-1:0] req_div = '0;
    logic                 INIT_audio;
    logic [AW-1:0]        sample_addr;
    logic                 busy;
    logic [1:0]           active_id;
    logic                 done;
    logic [1:0]           done_id;

    always #5 Clk = ~Clk;

    sfx_playback_scheduler dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .INIT_FINISH (INIT_FINISH),
        .data_over   (data_over),
        .req         (req),
        .req_base    (req_base),
        .req_len     (req_len),
        .req_div     (req_div),
        .INIT_audio  (INIT_audio),
        .sample_addr (sample_addr),
        .busy        (busy),
        .active_id   (active_id),
        .done        (done),
        .done_id     (done_id)
    );

    int n_checks = 0;
    int n_bad    = 0;
    bit scramble = 1'b0;
    int done_q[$];

    // Reference model: mode 0 idle, 1 load, 2 play, 3 done; idx = sample within clip,
    // wait = cycles spent on the current sample.
    int     m_mode = 0;
    bit [3:0] m_pend = '0;
    int     m_src = 0, m_base = 0, m_len = 0, m_div = 0, m_idx = 0, m_wait = 0;
    int     exp_addr = 0, exp_done_id = 0;
    bit     exp_done = 1'b0, exp_init = 1'b0;

`ifdef SFX_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    task automatic chk(input string tag, input int got, input int exp_v);
        n_checks++;
        if (got != exp_v) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp_v, $time);
        end
    endtask

    // Advance the model by the clock edge that just sampled the current input wires.
    task automatic model_tick();
        int w;
        int clr;
        bit hi;
        if (Reset) begin
            m_mode = 0; m_pend = '0; m_src = 0; exp_addr = 0;
            exp_done = 1'b0; exp_done_id = 0; exp_init = 1'b0;
            return;
        end
        exp_init = 1'b1;
        exp_done = 1'b0;
        clr = -1;
        case (m_mode)
            0: begin
                exp_addr = 0;
                if (INIT_FINISH && m_pend != 0) m_mode = 1;
            end
            1: begin
                w = 0;
                for (int i = N - 1; i >= 0; i--) if (m_pend[i]) w = i;
                clr = w; m_src = w;
                m_base = int'(req_base[w]); m_len = int'(req_len[w]); m_div = int'(req_div[w]);
                m_idx = 0; m_wait = 0; exp_addr = m_base;
                if (m_len == 0) begin
                    m_mode = 3; exp_done = 1'b1; exp_done_id = w;
                end else begin
                    m_mode = 2;
                end
            end
            2: begin
                hi = 1'b0;
                for (int j = 0; j < m_src; j++) if (m_pend[j]) hi = 1'b1;
                if (PREEMPT && hi) begin
                    m_mode = 1;
                end else if (m_wait >= m_div && data_over) begin
                    if (m_idx + 1 == m_len) begin
                        m_mode = 3; exp_done = 1'b1; exp_done_id = m_src;
                    end else begin
                        m_idx++; m_wait = 0;
                        exp_addr = (m_base + m_idx) % (1 << AW);
                    end
                end else begin
                    m_wait++;
                end
            end
            default: begin
                exp_addr = 0;
                m_mode = 0;
            end
        endcase
        if (clr >= 0) m_pend[clr] = 1'b0;
        m_pend = m_pend | req;
    endtask

    task automatic step(input bit rst, input bit [3:0] rq, input bit dov, input bit initf);
        @(negedge Clk);
        model_tick();
        chk("INIT_audio", int'(INIT_audio), int'(exp_init));
        chk("busy", int'(busy), int'(m_mode == 1 || m_mode == 2));
        chk("sample_addr", int'(sample_addr), exp_addr);
        chk("done", int'(done), int'(exp_done));
        if (exp_done) chk("done_id", int'(done_id), exp_done_id);
        if (m_mode == 2) chk("active_id", int'(active_id), m_src);
        if (done) begin
            done_q.push_back(int'(done_id));
            $display("clip done src=%0d t=%0t", done_id, $time);
        end
        Reset = rst; req = rq; data_over = dov; INIT_FINISH = initf;
        if (scramble) begin
            for (int s = 0; s < N; s++) begin
                req_base[s] = ($urandom_range(0, 3) == 0) ? AW'((1 << AW) - int'($urandom_range(1, 3)))
                                                          : AW'($urandom);
                req_len[s]  = AW'($urandom_range(0, 5));
                req_div[s]  = DW'($urandom_range(0, 3));
            end
        end
    endtask

    task automatic set_src(input int s, input int b, input int l, input int d);
        req_base[s] = AW'(b); req_len[s] = AW'(l); req_div[s] = DW'(d);
    endtask

    int n101;
    int n_done;

    initial begin
        // Test 1: basic clip, 3 cycles per sample step.
        step(1, 4'b0000, 0, 0);
        step(1, 4'b0000, 0, 0);
        set_src(2, 100, 3, 2);
        step(0, 4'b0100, 1, 1);
        n101 = 0;
        done_q.delete();
        for (int c = 0; c < 16; c++) begin
            step(0, 4'b0000, 1, 1);
            if (busy && sample_addr == AW'(101)) n101++;
        end
        chk("t1_cycles_at_101", n101, 3);
        chk("t1_done_count", done_q.size(), 1);
        if (done_q.size() > 0) chk("t1_done_id", done_q[0], 2);

        // Test 2: INIT_FINISH low blocks playback start.
        set_src(1, 50, 2, 0);
        step(0, 4'b0010, 1, 0);
        for (int c = 0; c < 6; c++) step(0, 4'b0000, 1, 0);
        for (int c = 0; c < 8; c++) step(0, 4'b0000, 1, 1);

        // Test 3: simultaneous requests, priority order 0 then 3.
        set_src(0, 200, 2, 1);
        set_src(3, 300, 1, 0);
        done_q.delete();
        step(0, 4'b1001, 1, 1);
        for (int c = 0; c < 20; c++) step(0, 4'b0000, 1, 1);
        chk("t3_done_count", done_q.size(), 2);
        if (done_q.size() >= 2) begin
            chk("t3_first", done_q[0], 0);
            chk("t3_second", done_q[1], 3);
        end

        // Test 4: data_over gating.
        set_src(2, 400, 4, 1);
        step(0, 4'b0100, 0, 1);
        for (int c = 0; c < 22; c++) step(0, 4'b0000, 0, 1);
        step(0, 4'b0000, 1, 1);
        for (int c = 0; c < 5; c++) step(0, 4'b0000, 0, 1);
        for (int c = 0; c < 15; c++) step(0, 4'b0000, 1, 1);

        // Test 5: higher-priority request during a clip of source 3.
        set_src(3, 500, 6, 1);
        set_src(1, 600, 2, 0);
        done_q.delete();
        step(0, 4'b1000, 1, 1);
        for (int c = 0; c < 5; c++) step(0, 4'b0000, 1, 1);
        step(0, 4'b0010, 1, 1);
        for (int c = 0; c < 30; c++) step(0, 4'b0000, 1, 1);
        n_done = done_q.size();
        chk("t5_done_count", n_done, PREEMPT ? 1 : 2);

        // Test 6: zero-length clip, then reset in mid-play.
        set_src(0, 650, 0, 2);
        step(0, 4'b0001, 1, 1);
        for (int c = 0; c < 6; c++) step(0, 4'b0000, 1, 1);
        set_src(2, 700, 5, 3);
        step(0, 4'b0100, 1, 1);
        for (int c = 0; c < 6; c++) step(0, 4'b0000, 1, 1);
        step(1, 4'b0001, 1, 1);
        for (int c = 0; c < 4; c++) step(0, 4'b0000, 1, 1);

        // Random traffic, including wrap-around bases and rare resets.
        scramble = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 299) == 0),
                 {($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0)},
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 19) != 0));
        end
        step(0, 4'b0000, 0, 1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
